// File: rtl/wb_arbiter2_pkg.sv
// wb_arbiter2_pkg: state encodings and grant one-hot constants for wb_arbiter2.
// Each state value is the one-hot grant it drives, so gnt_o is the state register.
// Shared by the top-level FSM and the round-robin picker.
package wb_arbiter2_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_GNT0 = 2'b01,
    ARB_GNT1 = 2'b10
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/wb_arb_rr.sv
// wb_arb_rr: 2-way round-robin picker; on a tie the master that was not granted last wins.
// Latency: purely combinational.
// Backpressure: none; ports are req[1:0] (requests), last (last granted master), pick[1:0] (one-hot, 00 if no request).
module wb_arb_rr
  import wb_arbiter2_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

  always_comb begin
    pick = GNT_NONE;
    case (req)
      2'b01:   pick = GNT_M0;
      2'b10:   pick = GNT_M1;
      2'b11:   pick = last ? GNT_M0 : GNT_M1;
      default: pick = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master / one-slave Wishbone arbiter, round-robin, grant held for the whole cyc window.
// Latency: 1 cycle from mX_cyc_i to s_cyc_o out of IDLE; zero-idle handoff between masters.
// Backpressure: the losing master simply sees no ack until granted; the slave throttles with s_ack_i.
// Ports: wb_clk_i/wb_rst_i (async, active-low); m0_*/m1_* master sides; s_* slave side; gnt_o one-hot grant.
// Option: define WB_ARB_TIMEOUT_EN to raise a one-cycle mX_err_o after TIMEOUT unacked strobe cycles.
module wb_arbiter2
  import wb_arbiter2_pkg::*;
#(
  parameter int AW      = 19,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  // master 0 (CPU)
  input  logic [DW-1:0] m0_dat_i,
  output logic [DW-1:0] m0_dat_o,
  input  logic [AW:1]   m0_adr_i,
  input  logic          m0_we_i,
  input  logic          m0_tga_i,
  input  logic [1:0]    m0_sel_i,
  input  logic          m0_stb_i,
  input  logic          m0_cyc_i,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  // master 1 (DMA / video)
  input  logic [DW-1:0] m1_dat_i,
  output logic [DW-1:0] m1_dat_o,
  input  logic [AW:1]   m1_adr_i,
  input  logic          m1_we_i,
  input  logic          m1_tga_i,
  input  logic [1:0]    m1_sel_i,
  input  logic          m1_stb_i,
  input  logic          m1_cyc_i,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  // slave
  output logic [DW-1:0] s_dat_o,
  input  logic [DW-1:0] s_dat_i,
  output logic [AW:1]   s_adr_o,
  output logic          s_we_o,
  output logic          s_tga_o,
  output logic [1:0]    s_sel_o,
  output logic          s_stb_o,
  output logic          s_cyc_o,
  input  logic          s_ack_i,
  output logic [1:0]    gnt_o
);

  arb_state_t state, state_nxt;
  logic       last, last_nxt;
  logic [1:0] rr_req, rr_pick;

  // While a master holds the grant only the other master may take over on handoff;
  // the holder re-requesting in its release cycle goes through IDLE first.
  assign rr_req = (state == ARB_GNT0) ? {m1_cyc_i, 1'b0} :
                  (state == ARB_GNT1) ? {1'b0, m0_cyc_i} :
                                        {m1_cyc_i, m0_cyc_i};

  wb_arb_rr u_rr (
    .req  (rr_req),
    .last (last),
    .pick (rr_pick)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state <= ARB_IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      ARB_IDLE: begin
        if (rr_pick == GNT_M0) begin
          state_nxt = ARB_GNT0;
          last_nxt  = 1'b0;
        end else if (rr_pick == GNT_M1) begin
          state_nxt = ARB_GNT1;
          last_nxt  = 1'b1;
        end
      end
      ARB_GNT0: begin
        if (!m0_cyc_i) begin
          if (rr_pick == GNT_M1) begin
            state_nxt = ARB_GNT1;
            last_nxt  = 1'b1;
          end else begin
            state_nxt = ARB_IDLE;
          end
        end
      end
      ARB_GNT1: begin
        if (!m1_cyc_i) begin
          if (rr_pick == GNT_M0) begin
            state_nxt = ARB_GNT0;
            last_nxt  = 1'b0;
          end else begin
            state_nxt = ARB_IDLE;
          end
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Slave side is a pure mux of the granted master, so s_cyc_o follows the
  // holder's cyc combinationally and drops in its release cycle.
  always_comb begin
    s_dat_o  = '0;
    s_adr_o  = '0;
    s_we_o   = 1'b0;
    s_tga_o  = 1'b0;
    s_sel_o  = 2'b00;
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    case (state)
      ARB_GNT0: begin
        s_dat_o  = m0_dat_i;
        s_adr_o  = m0_adr_i;
        s_we_o   = m0_we_i;
        s_tga_o  = m0_tga_i;
        s_sel_o  = m0_sel_i;
        s_stb_o  = m0_stb_i;
        s_cyc_o  = m0_cyc_i;
        m0_ack_o = s_ack_i;
      end
      ARB_GNT1: begin
        s_dat_o  = m1_dat_i;
        s_adr_o  = m1_adr_i;
        s_we_o   = m1_we_i;
        s_tga_o  = m1_tga_i;
        s_sel_o  = m1_sel_i;
        s_stb_o  = m1_stb_i;
        s_cyc_o  = m1_cyc_i;
        m1_ack_o = s_ack_i;
      end
      default: ;
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign gnt_o    = state;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] to_cnt;
  logic          to_hit;

  assign to_hit = (to_cnt == TO_LIMIT);

  // Counts consecutive unacked strobe cycles of the current grant; restarts
  // on every grant change so a new owner never inherits the old count.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      to_cnt <= '0;
    end else if ((state_nxt != state) || s_ack_i || !s_stb_o || to_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign m0_err_o = to_hit && (state == ARB_GNT0);
  assign m1_err_o = to_hit && (state == ARB_GNT1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: scenario bench for wb_arbiter2.
// Expected read data is queued per master when the slave acks and popped when that master's ack appears.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_wb_arbiter2;

  logic        clk;
  logic        wb_rst_i;
  logic [15:0] m0_dat_i, m0_dat_o, m1_dat_i, m1_dat_o;
  logic [19:1] m0_adr_i, m1_adr_i;
  logic        m0_we_i, m0_tga_i, m0_stb_i, m0_cyc_i, m0_ack_o, m0_err_o;
  logic        m1_we_i, m1_tga_i, m1_stb_i, m1_cyc_i, m1_ack_o, m1_err_o;
  logic [1:0]  m0_sel_i, m1_sel_i;
  logic [15:0] s_dat_o, s_dat_i;
  logic [19:1] s_adr_o;
  logic        s_we_o, s_tga_o, s_stb_o, s_cyc_o, s_ack_i;
  logic [1:0]  s_sel_o, gnt_o;

  int total = 0;
  int bad   = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  wb_arbiter2 #(.AW(19), .DW(16), .TIMEOUT(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_adr_i(m0_adr_i), .m0_we_i(m0_we_i),
    .m0_tga_i(m0_tga_i), .m0_sel_i(m0_sel_i), .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_adr_i(m1_adr_i), .m1_we_i(m1_we_i),
    .m1_tga_i(m1_tga_i), .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_adr_o(s_adr_o), .s_we_o(s_we_o),
    .s_tga_o(s_tga_o), .s_sel_o(s_sel_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
    .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time=%0t required<200000", $time);
    $fatal(1, "watchdog");
  end

  // Scoreboard: every ack seen by a master must match the next queued read word for it.
  always @(negedge clk) begin
    if (m0_ack_o) begin
      total++;
      if (q0.size() == 0) begin
        bad++;
        $display("FAIL sb_m0 unexpected ack: got dat=%h required no ack", m0_dat_o);
      end else begin
        logic [15:0] e0;
        e0 = q0.pop_front();
        if (m0_dat_o !== e0) begin
          bad++;
          $display("FAIL sb_m0 dat: got=%h required=%h", m0_dat_o, e0);
        end
      end
    end
    if (m1_ack_o) begin
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL sb_m1 unexpected ack: got dat=%h required no ack", m1_dat_o);
      end else begin
        logic [15:0] e1;
        e1 = q1.pop_front();
        if (m1_dat_o !== e1) begin
          bad++;
          $display("FAIL sb_m1 dat: got=%h required=%h", m1_dat_o, e1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b0;
    #3;
    wb_rst_i = 1'b1;
  endtask

  task automatic test_reset();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; s_ack_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({s_cyc_o, s_stb_o, gnt_o, m0_ack_o, m1_ack_o} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs: got cyc=%b stb=%b gnt=%b ack0=%b ack1=%b required all 0",
               s_cyc_o, s_stb_o, gnt_o, m0_ack_o, m1_ack_o);
    end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; s_ack_i = 1'b0;
    wb_rst_i = 1'b1;
    step();
  endtask

  task automatic test_single();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 19'h00100; m0_we_i = 1'b0;
    @(negedge clk);
    total++;
    if (s_cyc_o !== 1'b0) begin bad++; $display("FAIL single_latency s_cyc: got=%b required=0", s_cyc_o); end
    step();
    @(negedge clk);
    total++;
    if (s_cyc_o !== 1'b1 || gnt_o !== 2'b01 || s_adr_o !== 19'h00100) begin
      bad++;
      $display("FAIL single_grant: got cyc=%b gnt=%b adr=%h required 1 01 00100", s_cyc_o, gnt_o, s_adr_o);
    end
    step();
    s_ack_i = 1'b1; s_dat_i = 16'hBEEF; q0.push_back(16'hBEEF);
    @(negedge clk);
    total++;
    if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin
      bad++;
      $display("FAIL single_ack: got ack0=%b ack1=%b required 1 0", m0_ack_o, m1_ack_o);
    end
    step();
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    @(negedge clk);
    total++;
    if (s_cyc_o !== 1'b0) begin bad++; $display("FAIL single_release s_cyc: got=%b required=0", s_cyc_o); end
    step();
    @(negedge clk);
    total++;
    if (gnt_o !== 2'b00) begin bad++; $display("FAIL single_idle gnt: got=%b required=00", gnt_o); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_seq [3];
    exp_seq = '{2'b01, 2'b10, 2'b01};
    step();
    do_reset();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 19'h00200;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 19'h00300;
    step();
    @(negedge clk);
    total++;
    if (gnt_o !== 2'b01 || s_adr_o !== 19'h00200) begin
      bad++;
      $display("FAIL rr_tie_after_reset: got gnt=%b adr=%h required 01 00200", gnt_o, s_adr_o);
    end
    step();
    s_ack_i = 1'b1; s_dat_i = 16'h1234; q0.push_back(16'h1234);
    step();
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    @(negedge clk);
    total++;
    if (s_cyc_o !== 1'b0 || gnt_o !== 2'b01) begin
      bad++;
      $display("FAIL rr_handoff_gap: got cyc=%b gnt=%b required 0 01", s_cyc_o, gnt_o);
    end
    step();
    @(negedge clk);
    total++;
    if (gnt_o !== 2'b10 || s_adr_o !== 19'h00300 || s_cyc_o !== 1'b1) begin
      bad++;
      $display("FAIL rr_handoff: got gnt=%b adr=%h cyc=%b required 10 00300 1", gnt_o, s_adr_o, s_cyc_o);
    end
    step();
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
      step();
      @(negedge clk);
      total++;
      if (gnt_o !== exp_seq[i]) begin
        bad++;
        $display("FAIL rr_alternate[%0d]: got gnt=%b required=%b", i, gnt_o, exp_seq[i]);
      end
      m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
    end
  endtask

  task automatic test_unaligned();
    step();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 19'h00400;
    step();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_adr_i = 19'h00500;
    m1_dat_i = 16'hA5A5; m1_sel_i = 2'b10; m1_tga_i = 1'b1;
    step();
    s_ack_i = 1'b1; s_dat_i = 16'h1111; q0.push_back(16'h1111);
    step();
    s_ack_i = 1'b0; m0_stb_i = 1'b0;
    @(negedge clk);
    total++;
    if (s_stb_o !== 1'b0 || s_cyc_o !== 1'b1 || gnt_o !== 2'b01) begin
      bad++;
      $display("FAIL unal_gap: got stb=%b cyc=%b gnt=%b required 0 1 01", s_stb_o, s_cyc_o, gnt_o);
    end
    step();
    m0_stb_i = 1'b1;
    @(negedge clk);
    total++;
    if (s_stb_o !== 1'b1 || gnt_o !== 2'b01) begin
      bad++;
      $display("FAIL unal_second: got stb=%b gnt=%b required 1 01", s_stb_o, gnt_o);
    end
    step();
    s_ack_i = 1'b1; s_dat_i = 16'h2222; q0.push_back(16'h2222);
    step();
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    @(negedge clk);
    total++;
    if (gnt_o !== 2'b01 || s_cyc_o !== 1'b0) begin
      bad++;
      $display("FAIL unal_release: got gnt=%b cyc=%b required 01 0", gnt_o, s_cyc_o);
    end
    step();
    @(negedge clk);
    total++;
    if ({gnt_o, s_we_o, s_dat_o, s_sel_o, s_tga_o, s_cyc_o} !== {2'b10, 1'b1, 16'hA5A5, 2'b10, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL unal_m1_mux: got gnt=%b we=%b dat=%h sel=%b tga=%b cyc=%b required 10 1 a5a5 10 1 1",
               gnt_o, s_we_o, s_dat_o, s_sel_o, s_tga_o, s_cyc_o);
    end
  endtask

  task automatic test_reset_mid();
    step();
    m1_adr_i = 19'h7FFFF;
    @(negedge clk);
    total++;
    if (s_adr_o !== 19'h7FFFF) begin bad++; $display("FAIL rstmid_adr: got=%h required=7ffff", s_adr_o); end
    #2;
    wb_rst_i = 1'b0;
    #1;
    total++;
    if ({s_cyc_o, s_stb_o, s_we_o, s_tga_o, s_adr_o, s_dat_o, s_sel_o, gnt_o} !== '0) begin
      bad++;
      $display("FAIL rstmid_async: got cyc=%b stb=%b adr=%h dat=%h gnt=%b required all 0",
               s_cyc_o, s_stb_o, s_adr_o, s_dat_o, gnt_o);
    end
    step();
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 19'h00600;
    wb_rst_i = 1'b1;
    @(negedge clk);
    total++;
    if (gnt_o !== 2'b00) begin bad++; $display("FAIL rstmid_idle: got gnt=%b required=00", gnt_o); end
    step();
    @(negedge clk);
    total++;
    if (gnt_o !== 2'b01 || s_adr_o !== 19'h00600) begin
      bad++;
      $display("FAIL rstmid_m0_first: got gnt=%b adr=%h required 01 00600", gnt_o, s_adr_o);
    end
    step();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    step();
  endtask

  task automatic test_spurious_ack();
    s_ack_i = 1'b1; s_dat_i = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0 || gnt_o !== 2'b00) begin
        bad++;
        $display("FAIL spurious_ack[%0d]: got ack0=%b ack1=%b gnt=%b required 0 0 00", i, m0_ack_o, m1_ack_o, gnt_o);
      end
      step();
    end
    s_ack_i = 1'b0;
  endtask

  task automatic test_timeout();
    logic exp_err;
    step();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 19'h00700;
    step();
    for (int k = 0; k < 8; k++) begin
`ifdef WB_ARB_TIMEOUT_EN
      exp_err = (k == 4);
`else
      exp_err = 1'b0;
`endif
      @(negedge clk);
      total++;
      if (m0_err_o !== exp_err || m1_err_o !== 1'b0) begin
        bad++;
        $display("FAIL timeout[%0d]: got err0=%b err1=%b required %b 0", k, m0_err_o, m1_err_o, exp_err);
      end
      step();
    end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    step();
  endtask

  initial begin
    wb_rst_i = 1'b0;
    m0_dat_i = '0; m0_adr_i = '0; m0_we_i = 1'b0; m0_tga_i = 1'b0; m0_sel_i = 2'b11;
    m0_stb_i = 1'b0; m0_cyc_i = 1'b0;
    m1_dat_i = '0; m1_adr_i = '0; m1_we_i = 1'b0; m1_tga_i = 1'b0; m1_sel_i = 2'b11;
    m1_stb_i = 1'b0; m1_cyc_i = 1'b0;
    s_dat_i = '0; s_ack_i = 1'b0;

    test_reset();
    test_single();
    test_round_robin();
    test_unaligned();
    test_reset_mid();
    test_spurious_ack();
    test_timeout();

    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got pending m0=%0d m1=%0d required 0 0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
